// File: rtl/conv_pass_scheduler.sv
// Layer sequencer for the convolution core: per (co, ci) pass it fetches NW weights,
// launches one datapath pass, waits for completion, then advances the channel indices.
module conv_pass_scheduler #(
  parameter  int unsigned KERNEL_SIZE = 3,
  parameter  int unsigned CI          = 3,
  parameter  int unsigned CO          = 8,
  localparam int unsigned NW          = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned CIW         = (CI > 1) ? $clog2(CI) : 1,
  localparam int unsigned COW         = (CO > 1) ? $clog2(CO) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           pass_done,
  output logic           busy,
  output logic           wgt_read,
  output logic [NW-1:0]  set_wgt,
  output logic           pass_start,
  output logic           first_ci,
  output logic           last_ci,
  output logic [CIW-1:0] ci_idx,
  output logic [COW-1:0] co_idx,
  output logic           done
);

  localparam int unsigned WW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [WW-1:0]  r_wcnt, w_wcnt_nxt;
  logic [CIW-1:0] r_ci, w_ci_nxt;
  logic [COW-1:0] r_co, w_co_nxt;
  logic [NW-1:0]  r_set_wgt, w_set_wgt_nxt;
  logic           r_busy, r_wgt_read, r_pass_start, r_first_ci, r_last_ci, r_done;
  logic           w_busy_nxt;

  // Next state, counters and the values every output will take next cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_ci_nxt      = r_ci;
    w_co_nxt      = r_co;
    w_set_wgt_nxt = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_wcnt_nxt  = '0;
          w_ci_nxt    = '0;
          w_co_nxt    = '0;
        end
      end
      S_LOAD: begin
        // First fetched word lands in the highest weight register
        w_set_wgt_nxt = NW'(1) << (WW'(NW - 1) - r_wcnt);
        if (r_wcnt == WW'(NW - 1)) begin
          w_state_nxt = S_ISSUE;
          w_wcnt_nxt  = '0;
        end else begin
          w_wcnt_nxt = r_wcnt + WW'(1);
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (pass_done) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (r_ci < CIW'(CI - 1)) begin
          w_ci_nxt    = r_ci + CIW'(1);
          w_state_nxt = S_LOAD;
        end else if (r_co < COW'(CO - 1)) begin
          w_ci_nxt    = '0;
          w_co_nxt    = r_co + COW'(1);
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wcnt       <= '0;
      r_ci         <= '0;
      r_co         <= '0;
      r_set_wgt    <= '0;
      r_busy       <= 1'b0;
      r_wgt_read   <= 1'b0;
      r_pass_start <= 1'b0;
      r_first_ci   <= 1'b0;
      r_last_ci    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_ci         <= w_ci_nxt;
      r_co         <= w_co_nxt;
      r_set_wgt    <= w_set_wgt_nxt;
      r_busy       <= w_busy_nxt;
      r_wgt_read   <= (w_state_nxt == S_LOAD);
      r_pass_start <= (w_state_nxt == S_ISSUE);
      r_first_ci   <= w_busy_nxt && (w_ci_nxt == '0);
      r_last_ci    <= w_busy_nxt && (w_ci_nxt == CIW'(CI - 1));
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign busy       = r_busy;
  assign wgt_read   = r_wgt_read;
  assign set_wgt    = r_set_wgt;
  assign pass_start = r_pass_start;
  assign first_ci   = r_first_ci;
  assign last_ci    = r_last_ci;
  assign ci_idx     = r_ci;
  assign co_idx     = r_co;
  assign done       = r_done;

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Scoreboard bench for conv_pass_scheduler: expected passes are queued per layer,
// a negedge monitor checks strobes, timing and per-pass indices/flags.
module tb_conv_pass_scheduler;

  localparam int K   = 3;
  localparam int NCI = 2;
  localparam int NCO = 2;
  localparam int NW  = K * K;

  logic clk = 1'b0;
  logic rst_n;
  logic start_d, start_n, pd_r, pd_n;
  logic start, pass_done;
  logic busy, wgt_read, pass_start, first_ci, last_ci, done;
  logic [NW-1:0] set_wgt;
  logic [0:0] ci_idx, co_idx;

  logic start1, pd1;
  logic busy1, rd1, ps1, first1, last1, done1;
  logic [NW-1:0] set1;
  logic [0:0] ci1;
  logic [1:0] co1;

  always #5 clk = ~clk;

  assign start     = start_d | start_n;
  assign pass_done = pd_r | pd_n;

  conv_pass_scheduler #(.KERNEL_SIZE(K), .CI(NCI), .CO(NCO)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pass_done(pass_done),
    .busy(busy), .wgt_read(wgt_read), .set_wgt(set_wgt), .pass_start(pass_start),
    .first_ci(first_ci), .last_ci(last_ci), .ci_idx(ci_idx), .co_idx(co_idx),
    .done(done)
  );

  conv_pass_scheduler #(.KERNEL_SIZE(K), .CI(1), .CO(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pass_done(pd1),
    .busy(busy1), .wgt_read(rd1), .set_wgt(set1), .pass_start(ps1),
    .first_ci(first1), .last_ci(last1), .ci_idx(ci1), .co_idx(co1),
    .done(done1)
  );

  typedef struct {
    int co;
    int ci;
    bit first;
    bit last;
  } pass_t;

  pass_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_ps = 0, n_rd = 0, n_done = 0;
  int resp_delay = 5;
  bit rand_delay = 0;
  bit noise_en   = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: a layer is the row-major list of (co, ci) passes
  task automatic push_layer();
    for (int co = 0; co < NCO; co++)
      for (int ci = 0; ci < NCI; ci++)
        exp_q.push_back('{co, ci, (ci == 0), (ci == NCI - 1)});
  endtask

  // Datapath stand-in: answers each pass_start with a one-cycle pass_done
  initial begin
    int d;
    pd_r = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && pass_start) begin
        d = rand_delay ? int'($urandom_range(1, 8)) : resp_delay;
        repeat (d) @(negedge clk);
        pd_r = 1'b1;
        @(negedge clk);
        pd_r = 1'b0;
      end
    end
  end

  // Spurious start while busy, spurious pass_done during LOAD / ISSUE
  initial begin
    start_n = 1'b0;
    pd_n    = 1'b0;
    forever begin
      @(negedge clk);
      start_n = noise_en && busy && ($urandom_range(0, 2) == 0);
      pd_n    = noise_en && (wgt_read || pass_start) && ($urandom_range(0, 2) == 0);
    end
  end

  bit prev_rd = 0;
  int rd_pos  = 0;
  logic [NW-1:0] m_exp_set;
  bit m_exp_ps;
  pass_t m_e;

  // Monitor: weight fetch timing model plus per-pass scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 0;
      rd_pos  = 0;
    end else begin
      m_exp_set = prev_rd ? (NW'(1) << (NW - rd_pos)) : '0;
      m_exp_ps  = prev_rd && (rd_pos == NW);
      chk(set_wgt == m_exp_set, "set_wgt", longint'(set_wgt), longint'(m_exp_set));
      chk(pass_start == m_exp_ps, "pass_start_timing", longint'(pass_start), longint'(m_exp_ps));
      if (wgt_read) begin
        rd_pos = prev_rd ? rd_pos + 1 : 1;
        n_rd++;
      end else if (prev_rd) begin
        chk(rd_pos == NW, "wgt_read_run_len", rd_pos, NW);
      end
      prev_rd = wgt_read;
      if (!busy) chk({first_ci, last_ci} == 2'b00, "flags_idle", {first_ci, last_ci}, 0);
      if (pass_start) begin
        n_ps++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pass", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk(co_idx == m_e.co, "co_idx", longint'(co_idx), m_e.co);
          chk(ci_idx == m_e.ci, "ci_idx", longint'(ci_idx), m_e.ci);
          chk(first_ci == m_e.first, "first_ci", longint'(first_ci), longint'(m_e.first));
          chk(last_ci == m_e.last, "last_ci", longint'(last_ci), longint'(m_e.last));
          chk(busy == 1'b1, "busy_in_pass", longint'(busy), 1);
        end
      end
      if (done) begin
        n_done++;
        chk(exp_q.size() == 0, "done_with_passes_left", exp_q.size(), 0);
      end
    end
  end

  task automatic check_all_zero(input string nm);
    chk(busy == 0, {nm, "_busy"}, longint'(busy), 0);
    chk(wgt_read == 0, {nm, "_wgt_read"}, longint'(wgt_read), 0);
    chk(set_wgt == 0, {nm, "_set_wgt"}, longint'(set_wgt), 0);
    chk(pass_start == 0, {nm, "_pass_start"}, longint'(pass_start), 0);
    chk(first_ci == 0, {nm, "_first_ci"}, longint'(first_ci), 0);
    chk(last_ci == 0, {nm, "_last_ci"}, longint'(last_ci), 0);
    chk(ci_idx == 0, {nm, "_ci_idx"}, longint'(ci_idx), 0);
    chk(co_idx == 0, {nm, "_co_idx"}, longint'(co_idx), 0);
    chk(done == 0, {nm, "_done"}, longint'(done), 0);
  endtask

  task automatic run_layer(input string nm, input bit holdoff);
    int ps0, rd0, dn0;
    bit seen;
    logic [0:0] h_ci, h_co;
    push_layer();
    ps0 = n_ps; rd0 = n_rd; dn0 = n_done;
    @(negedge clk);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    chk(wgt_read == 1 && busy == 1, {nm, "_first_read"}, {busy, wgt_read}, 3);
    repeat (NW) @(negedge clk);
    chk(pass_start == 1 && set_wgt[0] == 1, {nm, "_first_issue"}, {pass_start, set_wgt[0]}, 3);
    if (holdoff) begin
      h_ci = ci_idx;
      h_co = co_idx;
      for (int i = 0; i < 99; i++) begin
        @(negedge clk);
        chk({wgt_read, pass_start, done} == 3'b000 && set_wgt == 0, "holdoff_strobes",
            {wgt_read, pass_start, done}, 0);
        chk(busy == 1, "holdoff_busy", longint'(busy), 1);
        chk(ci_idx == h_ci && co_idx == h_co, "holdoff_idx", {co_idx, ci_idx}, {h_co, h_ci});
      end
    end
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(seen, {nm, "_done_timeout"}, seen, 1);
    @(negedge clk);
    chk(n_ps - ps0 == NCO * NCI, {nm, "_pass_count"}, n_ps - ps0, NCO * NCI);
    chk(n_rd - rd0 == NCO * NCI * NW, {nm, "_read_count"}, n_rd - rd0, NCO * NCI * NW);
    chk(n_done - dn0 == 1, {nm, "_done_count"}, n_done - dn0, 1);
    chk(busy == 0 && done == 0, {nm, "_back_idle"}, {busy, done}, 0);
  endtask

  task automatic reset_mid_load();
    int rises, loads;
    bit prev, hit;
    push_layer();
    @(negedge clk);
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    rises = 1; loads = 1; prev = 1; hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (wgt_read && !prev) begin rises++; loads = 0; end
      if (wgt_read) loads++;
      prev = wgt_read;
      if (rises == 2 && loads == 4) hit = 1;
    end
    chk(hit, "reset_reach_pass2", hit, 1);
    chk(ci_idx == 1, "reset_pre_ci", longint'(ci_idx), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_load");
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk(wgt_read == 0 && busy == 0, "reset_hold", {busy, wgt_read}, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_ci1();
    bit seen;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int p = 0; p < 3; p++) begin
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        if (ps1) seen = 1; else @(negedge clk);
      end
      chk(seen, "ci1_pass_timeout", seen, 1);
      chk(first1 == 1 && last1 == 1, "ci1_flags", {first1, last1}, 3);
      chk(ci1 == 0, "ci1_ci_idx", longint'(ci1), 0);
      chk(co1 == p, "ci1_co_idx", longint'(co1), p);
      repeat (2) @(negedge clk);
      pd1 = 1'b1;
      @(negedge clk);
      pd1 = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1;
      else chk(ps1 == 0, "ci1_extra_pass", longint'(ps1), 0);
    end
    chk(seen, "ci1_done", seen, 1);
  endtask

  initial begin
    start_d = 1'b0;
    start1  = 1'b0;
    pd1     = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_layer("fixed5", 0);
    rand_delay = 1;
    noise_en   = 1;
    run_layer("noise_a", 0);
    run_layer("noise_b", 0);
    noise_en   = 0;
    rand_delay = 0;
    resp_delay = 100;
    run_layer("holdoff", 1);
    resp_delay = 5;
    reset_mid_load();
    run_layer("after_reset", 0);
    run_ci1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
